// File: rtl/angular_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : angular_filter_pkg
//  Description : Shared definitions for the angular-interpolation scheduler:
//                default sizes, FSM state type, 4-tap coefficient tables for
//                the cubic (fC) and gaussian (fG) filters, and the
//                round/clip helper applied to the filtered sum.
//  Revision    : 1.0 - initial release
// ============================================================================
package angular_filter_pkg;

  localparam int DEF_SW    = 8;
  localparam int DEF_MAX_N = 32;
  localparam int SUM_W     = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef logic signed [7:0] coef_t;
  typedef coef_t coef_set_t [4];

  // Cubic interpolation filter, indexed by iFact. Every set sums to 64.
  localparam coef_set_t COEF_FC [32] = '{
    '{ 8'sd0, 8'sd64,  8'sd0,  8'sd0}, '{-8'sd1, 8'sd63,  8'sd2,  8'sd0},
    '{-8'sd2, 8'sd62,  8'sd4,  8'sd0}, '{-8'sd2, 8'sd60,  8'sd7, -8'sd1},
    '{-8'sd2, 8'sd58, 8'sd10, -8'sd2}, '{-8'sd3, 8'sd57, 8'sd12, -8'sd2},
    '{-8'sd4, 8'sd56, 8'sd14, -8'sd2}, '{-8'sd4, 8'sd55, 8'sd15, -8'sd2},
    '{-8'sd4, 8'sd54, 8'sd16, -8'sd2}, '{-8'sd5, 8'sd53, 8'sd18, -8'sd2},
    '{-8'sd6, 8'sd52, 8'sd20, -8'sd2}, '{-8'sd6, 8'sd49, 8'sd24, -8'sd3},
    '{-8'sd6, 8'sd46, 8'sd28, -8'sd4}, '{-8'sd5, 8'sd44, 8'sd29, -8'sd4},
    '{-8'sd4, 8'sd42, 8'sd30, -8'sd4}, '{-8'sd4, 8'sd39, 8'sd33, -8'sd4},
    '{-8'sd4, 8'sd36, 8'sd36, -8'sd4}, '{-8'sd4, 8'sd33, 8'sd39, -8'sd4},
    '{-8'sd4, 8'sd30, 8'sd42, -8'sd4}, '{-8'sd4, 8'sd29, 8'sd44, -8'sd5},
    '{-8'sd4, 8'sd28, 8'sd46, -8'sd6}, '{-8'sd3, 8'sd24, 8'sd49, -8'sd6},
    '{-8'sd2, 8'sd20, 8'sd52, -8'sd6}, '{-8'sd2, 8'sd18, 8'sd53, -8'sd5},
    '{-8'sd2, 8'sd16, 8'sd54, -8'sd4}, '{-8'sd2, 8'sd15, 8'sd55, -8'sd4},
    '{-8'sd2, 8'sd14, 8'sd56, -8'sd4}, '{-8'sd2, 8'sd12, 8'sd57, -8'sd3},
    '{-8'sd2, 8'sd10, 8'sd58, -8'sd2}, '{-8'sd1,  8'sd7, 8'sd60, -8'sd2},
    '{ 8'sd0,  8'sd4, 8'sd62, -8'sd2}, '{ 8'sd0,  8'sd2, 8'sd63, -8'sd1}
  };

  // Gaussian smoothing filter, indexed by iFact. Every set sums to 64.
  localparam coef_set_t COEF_FG [32] = '{
    '{8'sd16, 8'sd32, 8'sd16,  8'sd0}, '{8'sd16, 8'sd32, 8'sd16,  8'sd0},
    '{8'sd15, 8'sd31, 8'sd17,  8'sd1}, '{8'sd15, 8'sd31, 8'sd17,  8'sd1},
    '{8'sd14, 8'sd30, 8'sd18,  8'sd2}, '{8'sd14, 8'sd30, 8'sd18,  8'sd2},
    '{8'sd13, 8'sd29, 8'sd19,  8'sd3}, '{8'sd13, 8'sd29, 8'sd19,  8'sd3},
    '{8'sd12, 8'sd28, 8'sd20,  8'sd4}, '{8'sd12, 8'sd28, 8'sd20,  8'sd4},
    '{8'sd11, 8'sd27, 8'sd21,  8'sd5}, '{8'sd11, 8'sd27, 8'sd21,  8'sd5},
    '{8'sd10, 8'sd26, 8'sd22,  8'sd6}, '{8'sd10, 8'sd26, 8'sd22,  8'sd6},
    '{ 8'sd9, 8'sd25, 8'sd23,  8'sd7}, '{ 8'sd9, 8'sd25, 8'sd23,  8'sd7},
    '{ 8'sd8, 8'sd24, 8'sd24,  8'sd8}, '{ 8'sd8, 8'sd24, 8'sd24,  8'sd8},
    '{ 8'sd7, 8'sd23, 8'sd25,  8'sd9}, '{ 8'sd7, 8'sd23, 8'sd25,  8'sd9},
    '{ 8'sd6, 8'sd22, 8'sd26, 8'sd10}, '{ 8'sd6, 8'sd22, 8'sd26, 8'sd10},
    '{ 8'sd5, 8'sd21, 8'sd27, 8'sd11}, '{ 8'sd5, 8'sd21, 8'sd27, 8'sd11},
    '{ 8'sd4, 8'sd20, 8'sd28, 8'sd12}, '{ 8'sd4, 8'sd20, 8'sd28, 8'sd12},
    '{ 8'sd3, 8'sd19, 8'sd29, 8'sd13}, '{ 8'sd3, 8'sd19, 8'sd29, 8'sd13},
    '{ 8'sd2, 8'sd18, 8'sd30, 8'sd14}, '{ 8'sd2, 8'sd18, 8'sd30, 8'sd14},
    '{ 8'sd1, 8'sd17, 8'sd31, 8'sd15}, '{ 8'sd1, 8'sd17, 8'sd31, 8'sd15}
  };

  function automatic coef_t coef_lookup(input logic filt, input logic [4:0] ifact,
                                        input logic [1:0] tap);
    return filt ? COEF_FG[ifact][tap] : COEF_FC[ifact][tap];
  endfunction

  localparam logic signed [SUM_W:0] CLIP_MAX = (SUM_W+1)'((1 << DEF_SW) - 1);

  // (sum + 32) >>> 6, clipped to the unsigned sample range.
  function automatic logic [DEF_SW-1:0] round_clip(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W:0] t;
    t = $signed({sum[SUM_W-1], sum}) + 18'sd32;
    t = t >>> 6;
    if (t < 0)
      return '0;
    else if (t > CLIP_MAX)
      return '1;
    else
      return t[DEF_SW-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/angular_tap_mcm.sv
`default_nettype none
// ============================================================================
//  Module      : angular_tap_mcm
//  Description : One filter tap: multiplies an unsigned sample by the table
//                coefficient selected by (filt, ifact, tap) using shifted
//                partial sums of the coefficient magnitude, then applies sign.
//  Ports       : sample - unsigned input sample
//                filt   - 0 = cubic, 1 = gaussian
//                ifact  - fractional position 0..31
//                tap    - tap index 0..3
//                prod   - signed product
//  Revision    : 1.0 - initial release
// ============================================================================
module angular_tap_mcm
  import angular_filter_pkg::*;
#(
  parameter int SW = DEF_SW
) (
  input  logic [SW-1:0]        sample,
  input  logic                 filt,
  input  logic [4:0]           ifact,
  input  logic [1:0]           tap,
  output logic signed [SW+7:0] prod
);

  always_comb begin
    coef_t           c;
    logic [7:0]      mag;
    logic [SW+7:0]   acc;
    c   = coef_lookup(filt, ifact, tap);
    mag = c[7] ? -c : c;
    acc = '0;
    for (int b = 0; b < 8; b++) begin
      if (mag[b]) acc = acc + ((SW+8)'(sample) << b);
    end
    prod = c[7] ? -$signed(acc) : $signed(acc);
  end

endmodule
`default_nettype wire

// File: rtl/angular_filter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : angular_filter_scheduler
//  Description : Accepts a row command, buffers n+3 reference samples, then
//                issues one 4-tap filtered sample per cycle through a
//                two-stage (sum, round/clip) pipeline with backpressure.
//  Ports       : cmd_*  - row command (ifact, filter select, sample count)
//                ref_*  - reference sample stream, increasing index
//                out_*  - predicted sample stream, out_last on final sample
//                busy   - any state other than IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module angular_filter_scheduler
  import angular_filter_pkg::*;
#(
  parameter int MAX_N = DEF_MAX_N,
  parameter int SW    = DEF_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_ifact,
  input  logic          cmd_filt,
  input  logic [5:0]    cmd_n,
  input  logic          ref_valid,
  output logic          ref_ready,
  input  logic [SW-1:0] ref_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int DEPTH = MAX_N + 3;

  state_t                   state, state_nx;
  logic                     cmd_ready_q;
  logic [4:0]               ifact_q;
  logic                     filt_q;
  logic [5:0]               n_q, n_sat, load_cnt, issue_cnt;
  logic [SW-1:0]            line_buf [DEPTH];
  logic                     s1_valid, s1_last;
  logic signed [SUM_W-1:0]  s1_sum, sum_w;
  logic signed [SW+7:0]     prod [4];
  logic                     stall, issue, cmd_hs, load_hs, last_hs, last_issue;

  assign stall      = out_valid && !out_ready;
  assign ref_ready  = (state == LOAD);
  assign busy       = (state != IDLE);
  assign cmd_ready  = cmd_ready_q;
  assign cmd_hs     = cmd_valid && cmd_ready;
  assign load_hs    = ref_valid && ref_ready;
  assign issue      = (state == RUN) && !stall;
  assign last_issue = (issue_cnt == n_q - 6'd1);
  assign last_hs    = out_valid && out_ready && out_last;

  always_comb begin
    n_sat = cmd_n;
    if (cmd_n == 6'd0)
      n_sat = 6'd1;
    else if (cmd_n > 6'(MAX_N))
      n_sat = 6'(MAX_N);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_hs) state_nx = LOAD;
      LOAD:    if (load_hs && load_cnt == n_q + 6'd2) state_nx = RUN;
      RUN:     if (issue && last_issue) state_nx = DRAIN;
      DRAIN:   if (last_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered ready keeps cmd_ready low through reset and raises it the
  // cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      ifact_q     <= '0;
      filt_q      <= 1'b0;
      n_q         <= '0;
      load_cnt    <= '0;
      issue_cnt   <= '0;
    end else begin
      state       <= state_nx;
      cmd_ready_q <= (state_nx == IDLE);
      if (cmd_hs) begin
        ifact_q  <= cmd_ifact;
        filt_q   <= cmd_filt;
        n_q      <= n_sat;
        load_cnt <= '0;
      end
      if (load_hs) load_cnt <= load_cnt + 6'd1;
      if (state == LOAD && state_nx == RUN) issue_cnt <= '0;
      if (issue) issue_cnt <= issue_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_hs) line_buf[load_cnt] <= ref_data;
  end

  generate
    for (genvar k = 0; k < 4; k++) begin : g_tap
      logic [5:0] idx;
      assign idx = issue_cnt + 6'(k);
      angular_tap_mcm #(.SW(SW)) u_mcm (
        .sample (line_buf[idx]),
        .filt   (filt_q),
        .ifact  (ifact_q),
        .tap    (2'(k)),
        .prod   (prod[k])
      );
    end
  endgenerate

  assign sum_w = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]) + SUM_W'(prod[3]);

  // Both stages advance together; a stall freezes the whole pipe so no
  // sample is dropped or duplicated.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= issue;
      s1_last   <= issue && last_issue;
      if (issue) s1_sum <= sum_w;
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) out_data <= SW'(round_clip(s1_sum));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_angular_filter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_angular_filter_scheduler
//  Description : Self-checking bench for angular_filter_scheduler. Expected
//                samples come from an arithmetic model of the 4-tap filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_angular_filter_scheduler;

  localparam int SW    = 8;
  localparam int MAX_N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_ifact;
  logic          cmd_filt;
  logic [5:0]    cmd_n;
  logic          ref_valid;
  logic          ref_ready;
  logic [SW-1:0] ref_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  angular_filter_scheduler #(.MAX_N(MAX_N), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ifact (cmd_ifact),
    .cmd_filt  (cmd_filt),
    .cmd_n     (cmd_n),
    .ref_valid (ref_valid),
    .ref_ready (ref_ready),
    .ref_data  (ref_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // First half of the cubic table; the second half is its mirror image.
  int fc_half [17][4] = '{
    '{ 0, 64,  0,  0}, '{-1, 63,  2,  0}, '{-2, 62,  4,  0}, '{-2, 60,  7, -1},
    '{-2, 58, 10, -2}, '{-3, 57, 12, -2}, '{-4, 56, 14, -2}, '{-4, 55, 15, -2},
    '{-4, 54, 16, -2}, '{-5, 53, 18, -2}, '{-6, 52, 20, -2}, '{-6, 49, 24, -3},
    '{-6, 46, 28, -4}, '{-5, 44, 29, -4}, '{-4, 42, 30, -4}, '{-4, 39, 33, -4},
    '{-4, 36, 36, -4}
  };

  function automatic int coef(int filt, int p, int t);
    if (filt != 0) begin
      case (t)
        0:       return 16 - p / 2;
        1:       return 32 - p / 2;
        2:       return 16 + p / 2;
        default: return p / 2;
      endcase
    end
    if (p <= 16) return fc_half[p][t];
    return fc_half[32 - p][3 - t];
  endfunction

  function automatic int ref_pred(int filt, int p, int r0, int r1, int r2, int r3);
    int s, t, q;
    s = coef(filt, p, 0) * r0 + coef(filt, p, 1) * r1 + coef(filt, p, 2) * r2 + coef(filt, p, 3) * r3;
    t = s + 32;
    q = (t >= 0) ? t / 64 : -((-t + 63) / 64);
    if (q < 0) return 0;
    if (q > 255) return 255;
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one row starting at a negedge. mode: 0 flat 100, 1 ramp 4k,
  // 2 10k+1, 3 clip-high pattern, 4 clip-low pattern, other random.
  task automatic run_row(input string tag, input int filt, input int ifact, input int n_cmd,
                         input int mode, input bit bp, input bit gaps, input bit abort_mid);
    int nn, cyc, loaded, beats, last_load, k;
    bit done, seen_first, stalled_prev;
    logic [SW-1:0] prev_data;
    logic prev_last;
    int refs [MAX_N+3];
    int expv [MAX_N];
    nn = (n_cmd == 0) ? 1 : ((n_cmd > MAX_N) ? MAX_N : n_cmd);
    for (int j = 0; j < nn + 3; j++) begin
      case (mode)
        0:       refs[j] = 100;
        1:       refs[j] = 4 * j;
        2:       refs[j] = 10 * j + 1;
        3:       refs[j] = (j == 1 || j == 2) ? 255 : 0;
        4:       refs[j] = (j == 0 || j == 3) ? 255 : 0;
        default: refs[j] = int'($urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < nn; i++)
      expv[i] = ref_pred(filt, ifact, refs[i], refs[i+1], refs[i+2], refs[i+3]);

    cmd_valid = 1'b1;
    cmd_filt  = filt[0];
    cmd_ifact = ifact[4:0];
    cmd_n     = n_cmd[5:0];
    ref_valid = 1'b1;
    ref_data  = 8'($urandom);
    out_ready = 1'b1;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/cmd_accept"}, 32'(cmd_ready), 1);

    @(negedge clk);
    cyc = 0; loaded = 0; beats = 0; last_load = -100;
    done = 0; seen_first = 0; stalled_prev = 0;
    prev_data = '0; prev_last = 1'b0;
    while (!done && cyc < 600) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (loaded < nn + 3) begin
        ref_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        ref_data  = 8'(refs[loaded]);
      end else begin
        ref_valid = 1'($urandom_range(0, 1));
        ref_data  = 8'($urandom);
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_n     = 6'($urandom);
      cmd_ifact = 5'($urandom);
      cmd_filt  = 1'($urandom);

      if (stalled_prev) begin
        chk({tag, "/stall_valid"}, 32'(out_valid), 1);
        chk({tag, "/stall_data"}, 32'(out_data), 32'(prev_data));
        chk({tag, "/stall_last"}, 32'(out_last), 32'(prev_last));
      end
      if (cyc == last_load + 1) begin
        chk({tag, "/ref_ready_in_run"}, 32'(ref_ready), 0);
        chk({tag, "/busy_in_run"}, 32'(busy), 1);
      end
      if (ref_valid && ref_ready) begin
        loaded++;
        if (loaded == nn + 3) last_load = cyc;
      end
      if (out_valid) begin
        if (!seen_first) begin
          seen_first = 1;
          chk({tag, "/first_valid_cycle"}, cyc, last_load + 3);
        end
        if (out_ready) begin
          chk($sformatf("%s/data[%0d]", tag, beats), 32'(out_data), expv[beats]);
          chk($sformatf("%s/last[%0d]", tag, beats), 32'(out_last), 32'(beats == nn - 1));
          if (beats == nn - 1) begin
            if (!bp) chk({tag, "/last_beat_cycle"}, cyc, last_load + nn + 2);
            done = 1;
          end
          beats++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last    = out_last;
      if (abort_mid && cyc == last_load + 6) begin
        rst  = 1'b1;
        done = 1;
      end
      if (done) cmd_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!done) chk({tag, "/row_timeout_beats"}, beats, nn);
    if (!abort_mid) begin
      chk({tag, "/post_busy"}, 32'(busy), 0);
      chk({tag, "/post_out_valid"}, 32'(out_valid), 0);
      chk({tag, "/post_cmd_ready"}, 32'(cmd_ready), 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "/ref_ready"}, 32'(ref_ready), 0);
    chk({tag, "/out_valid"}, 32'(out_valid), 0);
    chk({tag, "/out_data"}, 32'(out_data), 0);
    chk({tag, "/out_last"}, 32'(out_last), 0);
    chk({tag, "/busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_ifact = '0; cmd_filt = 1'b0; cmd_n = '0;
    ref_valid = 1'b0; ref_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_row("flat",     0,  9,  8, 0, 1'b0, 1'b0, 1'b0);
    run_row("ramp",     0, 16, 32, 1, 1'b0, 1'b0, 1'b0);
    run_row("integer",  0,  0,  4, 2, 1'b0, 1'b0, 1'b0);
    run_row("clip_hi",  0, 16,  1, 3, 1'b0, 1'b0, 1'b0);
    run_row("clip_lo",  0, 16,  1, 4, 1'b0, 1'b0, 1'b0);
    run_row("ramp_bp",  0, 16, 32, 1, 1'b1, 1'b1, 1'b0);
    run_row("n_zero",   1,  7,  0, 5, 1'b0, 1'b1, 1'b0);
    run_row("n_sat",    0, 23, 63, 5, 1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++)
      run_row($sformatf("rand%0d", r), int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 40)), 5, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);

    run_row("abort", 1, 12, 16, 5, 1'b0, 1'b0, 1'b1);
    chk_reset_outputs("abort_reset");
    rst = 1'b0;
    @(negedge clk);
    run_row("after_abort", 0, 5, 4, 5, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/angular_filter_scheduler.md
Name: angular_filter_scheduler

Overview:
- Sequences the 4-tap angular-interpolation datapath for one predicted row: accepts a row command, loads the reference-sample line into a local buffer, then issues one filtered sample per cycle through a 2-stage multiply/round/clip pipeline.
- Coefficient products are built from shift-add constant multipliers, as in the rest of the accelerator.
- Sits between the reference-sample fetch unit and the prediction-row writer.

Parameters:
- MAX_N, 32, maximum predicted samples per row; buffer depth is MAX_N+3.
- SW, 8, sample bit width (unsigned).

Ports:
- clk  in  1  system clock; the block uses this single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  row command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_ifact  in  5  fractional position iFact, 0..31.
- cmd_filt  in  1  filter select: 0 = fC (cubic), 1 = fG (gaussian).
- cmd_n  in  6  predicted samples in the row, 1..MAX_N.
- ref_valid  in  1  reference sample valid.
- ref_ready  out  1  high only in LOAD.
- ref_data  in  SW  reference sample ref[k], streamed in increasing k.
- out_valid  out  1  filtered sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  SW  predicted sample.
- out_last  out  1  marks sample cmd_n-1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 the cycle after rst deasserts. ref_ready=0, out_valid=0, out_data=0, out_last=0, busy=0. State=IDLE, counters=0, pipeline valids=0.
- Reset mid-row discards the buffer and pipeline contents. No partial output appears after reset.

States:
- IDLE: cmd_valid&&cmd_ready latches ifact, filt and n, clears load_cnt, and moves to LOAD.
- LOAD: each ref_valid&&ref_ready writes buf[load_cnt] and increments load_cnt. After the write with load_cnt==n+2 (n+3 samples total), go to RUN with issue_cnt=0.
- RUN: issues index i=issue_cnt into stage 1 when the pipeline is not stalled, then increments issue_cnt. After issuing i=n-1, go to DRAIN.
- DRAIN: wait until the out_last beat handshakes (out_valid&&out_ready&&out_last), then return to IDLE. A new cmd may be accepted the following cycle.

Coefficients and arithmetic:
- Coefficients come from the package table: coef[filt][ifact][0..3], signed 8-bit, each set summing to 64.
- ifact=0 gives {0,64,0,0} for fC.
- Stage 1 (registered): sum = c0*buf[i] + c1*buf[i+1] + c2*buf[i+2] + c3*buf[i+3]. Products are formed by shift-add from the table constants; no generic multipliers. Sum is signed 17 bits.
- Stage 2 (registered to out_*): y = (sum+32)>>>6 (arithmetic shift), clipped to [0, 2^SW-1]. out_last = (i==n-1).
- Latency: the first out_valid is asserted 2 cycles after the first RUN cycle. With out_ready held high, throughput is 1 sample/cycle and a row occupies n+3 load cycles plus n+2 cycles.

Backpressure:
- Stall = out_valid && !out_ready.
- While stalled, stage 1, stage 2 and issue_cnt all hold. out_data and out_last stay stable.
- There are no bubbles and no dropped or duplicated samples.

Boundary conditions:
- cmd_n=0: treated as 1.
- cmd_n>MAX_N: saturated to MAX_N.
- cmd_valid outside IDLE: ignored, because cmd_ready=0.
- ref_valid outside LOAD: ignored.
- ref_valid gaps in LOAD: loading pauses and no state changes.

Decomposition:
- Package angular_filter_pkg holds:
  - SW and MAX_N defaults.
  - The state enum: IDLE, LOAD, RUN, DRAIN.
  - The 2×32×4 coefficient constants for fC and fG.
  - A function for round and clip.
- Natural sub-module: angular_tap_mcm. It is combinational and takes one sample plus filt/ifact/tap index. It returns the signed shift-add product, with one instance per tap (4 instances).

Test Plan:
- Flat line: filt=0, ifact=9, n=8, all ref=100, out_ready=1 -> 8 outputs of 100. out_last only on the 8th beat. First out_valid 2 cycles after RUN entry.
- Ramp, half-pel: filt=0, ifact=16, n=32, ref[k]=4k -> out[i]=4i+6, i=0..31.
- Integer position: filt=0, ifact=0, n=4, ref[k]=10k+1 -> outputs 11, 21, 31, 41.
- Clip both rails: ifact=16, n=1, ref={0,255,255,0} -> 255. ref={255,0,0,255} -> 0.
- Backpressure: as the ramp case, but out_ready toggles 1,0,0,1 and ref_valid has random gaps. Required: identical output sequence, out_data stable while stalled, exactly n beats.
- Reset mid-row: assert rst for 1 cycle during RUN at i=5 -> next cycle all outputs at reset values. A new n=4 command then completes correctly with no stale beats.
